button_conditioner: RTL and testbench

Conditions the two raw push-button inputs of the LED board into clean, single-cycle command pulses and debounced levels for the downstream 8-bit LED counter (its `count` and `clear` inputs). Each button passes through a two-flop synchroniser and a debounce state machine in the `clock` domain. An optional auto-repeat feature generates repeated `count` pulses while the count button is held.

---
 rtl/button_pkg.sv | 26 ++
 rtl/button_conditioner_if.sv | 20 ++
 rtl/debounce_channel.sv | 88 ++++++++
 rtl/button_conditioner.sv | 86 ++++++++
 tb/tb_button_conditioner.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the LED-board button conditioner: channel FSM
// encoding and default timing constants for a 12 MHz system clock.
package button_pkg;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  typedef enum logic [1:0] {
    IDLE         = ST_IDLE,
    PRESS_WAIT   = ST_PRESS_WAIT,
    HELD         = ST_HELD,
    RELEASE_WAIT = ST_RELEASE_WAIT
  } btn_state_e;

  localparam int unsigned CLK_HZ              = 12_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 50;  // 20 ms
  localparam int unsigned DEF_REPEAT_DELAY    = CLK_HZ / 2;   // 0.5 s
  localparam int unsigned DEF_REPEAT_PERIOD   = CLK_HZ / 10;  // 0.1 s

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button-side bundle: raw asynchronous button inputs in, conditioned
// pulses and debounced levels out.
interface button_conditioner_if;
  logic btn_count_raw;
  logic btn_clear_raw;
  logic count;
  logic clear;
  logic count_level;
  logic clear_level;

  modport master (
    output btn_count_raw, btn_clear_raw,
    input  count, clear, count_level, clear_level
  );

  modport slave (
    input  btn_count_raw, btn_clear_raw,
    output count, clear, count_level, clear_level
  );
endinterface

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, debounce FSM and counter.
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   IDLE         | button released and accepted as released
//   PRESS_WAIT   | s high, counting stable cycles before accepting press
//   HELD         | press accepted, level high
//   RELEASE_WAIT | s low, counting stable cycles before accepting release
module debounce_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic clear_n,
  input  logic btn_raw,
  output logic level,
  output logic press,
  output logic held
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  btn_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;
  logic          w_s;

  assign w_s = r_sync[1];

  // Synchronise the raw button and walk the debounce FSM; press is a one-cycle pulse.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_sync  <= 2'b00;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], btn_raw};
      r_press <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_s) begin
            r_state <= PRESS_WAIT;
            r_cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!w_s) begin
            r_state <= IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= HELD;
            r_level <= 1'b1;
            r_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        HELD: begin
          if (!w_s) begin
            r_state <= RELEASE_WAIT;
            r_cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (w_s) begin
            r_state <= HELD;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= IDLE;
            r_level <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign level = r_level;
  assign press = r_press;
  assign held  = (r_state == HELD);

endmodule

// File: rtl/button_conditioner.sv
// Top of the button conditioner: two debounce channels, optional count
// auto-repeat (enabled by defining BUTTON_CONDITIONER_AUTOREPEAT_EN) and
// clear-over-count arbitration. Outputs are gated registers only, so no
// input reaches an output without passing through flops.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                  clock,
  input  logic                  clear_n,
  button_conditioner_if.slave   bus
);

  logic w_cnt_level, w_cnt_press, w_cnt_held;
  logic w_clr_level, w_clr_press, w_clr_held;
  logic w_rep_pulse;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_count_ch (
    .clock   (clock),
    .clear_n (clear_n),
    .btn_raw (bus.btn_count_raw),
    .level   (w_cnt_level),
    .press   (w_cnt_press),
    .held    (w_cnt_held)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_ch (
    .clock   (clock),
    .clear_n (clear_n),
    .btn_raw (bus.btn_clear_raw),
    .level   (w_clr_level),
    .press   (w_clr_press),
    .held    (w_clr_held)
  );

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  localparam int RW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [RW-1:0] REP_FIRST_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_NEXT_LAST  = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] r_rep_cnt;
  logic          r_rep_first;
  logic          r_rep_pulse;
  logic          w_unused_held;

  // Repeat timer for the count button: restarts whenever the channel leaves HELD.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
      r_rep_pulse <= 1'b0;
    end else if (!w_cnt_held) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
      r_rep_pulse <= 1'b0;
    end else begin
      r_rep_pulse <= 1'b0;
      if (r_rep_cnt == (r_rep_first ? REP_FIRST_LAST : REP_NEXT_LAST)) begin
        r_rep_pulse <= 1'b1;
        r_rep_cnt   <= '0;
        r_rep_first <= 1'b0;
      end else begin
        r_rep_cnt <= r_rep_cnt + RW'(1);
      end
    end
  end

  assign w_rep_pulse   = r_rep_pulse;
  assign w_unused_held = w_clr_held;
`else
  // Repeat timing is accepted for interface compatibility but has no effect here.
  logic w_unused_cfg;
  assign w_rep_pulse  = 1'b0;
  assign w_unused_cfg = w_cnt_held ^ w_clr_held ^ (REPEAT_DELAY == 0) ^ (REPEAT_PERIOD == 0);
`endif

  // A clear pulse wins over a coincident count pulse; the count is simply lost.
  assign bus.clear       = w_clr_press;
  assign bus.count       = (w_cnt_press | w_rep_pulse) & ~w_clr_press;
  assign bus.count_level = w_cnt_level;
  assign bus.clear_level = w_clr_level;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=5. Each cycle compares
// {count, clear, count_level, clear_level} against hand-derived values.
module tb_button_conditioner;

  logic clock = 1'b0;
  logic clear_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  button_conditioner_if bif();

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bif)
  );

  always #5 clock = ~clock;

  // Advance one rising edge, then settle 1 ns before sampling or driving.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Auto-repeat pulse expected at edge e, HELD entered at edge entry,
  // repeat possible only up to edge last_ok (HELD left at last_ok).
  function automatic logic rep_hit(input int e, input int entry, input int last_ok);
    int d;
    d = e - entry;
    if (e > last_ok) return 1'b0;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    if (d == 20) return 1'b1;
    if (d > 20 && ((d - 20) % 5) == 0) return 1'b1;
`endif
    return (d < -1000) ? 1'b1 : 1'b0;
  endfunction

  task automatic do_reset();
    bif.btn_count_raw = 1'b0;
    bif.btn_clear_raw = 1'b0;
    clear_n = 1'b0;
    tick();
    tick();
    clear_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    bif.btn_count_raw = 1'b1;
    bif.btn_clear_raw = 1'b1;
    clear_n = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      obs = {bif.count, bif.clear, bif.count_level, bif.clear_level};
      vectors++;
      if (obs !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_hold edge %0d: outputs %b, expected 0000", e, obs);
      end
    end
    bif.btn_count_raw = 1'b0;
    bif.btn_clear_raw = 1'b0;
    clear_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      obs = {bif.count, bif.clear, bif.count_level, bif.clear_level};
      vectors++;
      if (obs !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_idle edge %0d: outputs %b, expected 0000", e, obs);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] obs, exp;
    do_reset();
    bif.btn_count_raw = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      tick();
      exp = {(e == 7) | rep_hit(e, 7, 33), 1'b0, (e >= 7 && e < 37), 1'b0};
      obs = {bif.count, bif.clear, bif.count_level, bif.clear_level};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL clean_press edge %0d: outputs %b, expected %b", e, obs, exp);
      end
      if (e == 30) bif.btn_count_raw = 1'b0;
    end
  endtask

  task automatic test_bounce();
    logic [3:0] obs;
    do_reset();
    bif.btn_count_raw = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      obs = {bif.count, bif.clear, bif.count_level, bif.clear_level};
      vectors++;
      if (obs !== 4'b0000) begin
        miscompares++;
        $display("FAIL bounce edge %0d: outputs %b, expected 0000", e, obs);
      end
      bif.btn_count_raw = ((e + 1) <= 20) && (((e + 1) % 2) == 1);
    end
  endtask

  task automatic test_both();
    logic [3:0] obs, exp;
    logic lv;
    do_reset();
    bif.btn_count_raw = 1'b1;
    bif.btn_clear_raw = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      tick();
      lv  = (e >= 7 && e < 19);
      exp = {1'b0, (e == 7), lv, lv};
      obs = {bif.count, bif.clear, bif.count_level, bif.clear_level};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL both_buttons edge %0d: outputs %b, expected %b", e, obs, exp);
      end
      if (e == 12) begin
        bif.btn_count_raw = 1'b0;
        bif.btn_clear_raw = 1'b0;
      end
    end
  endtask

  task automatic test_clear_only();
    logic [3:0] obs, exp;
    do_reset();
    bif.btn_clear_raw = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      exp = {1'b0, (e == 7), 1'b0, (e >= 7 && e < 37)};
      obs = {bif.count, bif.clear, bif.count_level, bif.clear_level};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL clear_only edge %0d: outputs %b, expected %b", e, obs, exp);
      end
      if (e == 30) bif.btn_clear_raw = 1'b0;
    end
  endtask

  task automatic test_reset_mid_press();
    logic [3:0] obs, exp;
    do_reset();
    bif.btn_count_raw = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      exp = {(e == 15), 1'b0, (e >= 15), 1'b0};
      obs = {bif.count, bif.clear, bif.count_level, bif.clear_level};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL reset_mid_press edge %0d: outputs %b, expected %b", e, obs, exp);
      end
      if (e == 4) clear_n = 1'b0;
      if (e == 8) clear_n = 1'b1;
    end
    bif.btn_count_raw = 1'b0;
  endtask

  task automatic test_autorepeat();
    logic [3:0] obs, exp;
    do_reset();
    bif.btn_count_raw = 1'b1;
    for (int e = 1; e <= 50; e++) begin
      tick();
      exp = {(e == 7) | rep_hit(e, 7, 43), 1'b0, (e >= 7 && e < 47), 1'b0};
      obs = {bif.count, bif.clear, bif.count_level, bif.clear_level};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL autorepeat edge %0d: outputs %b, expected %b", e, obs, exp);
      end
      if (e == 40) bif.btn_count_raw = 1'b0;
    end
  endtask

  task automatic test_release_glitch();
    logic [3:0] obs, exp;
    do_reset();
    bif.btn_count_raw = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      exp = {(e == 7), 1'b0, (e >= 7), 1'b0};
      obs = {bif.count, bif.clear, bif.count_level, bif.clear_level};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL release_glitch edge %0d: outputs %b, expected %b", e, obs, exp);
      end
      if (e == 12) bif.btn_count_raw = 1'b0;
      if (e == 13) bif.btn_count_raw = 1'b1;
    end
    bif.btn_count_raw = 1'b0;
    for (int e = 1; e <= 12; e++) tick();
    obs = {bif.count, bif.clear, bif.count_level, bif.clear_level};
    vectors++;
    if (obs !== 4'b0000) begin
      miscompares++;
      $display("FAIL glitch_final_release: outputs %b, expected 0000", obs);
    end
  endtask

  initial begin
    bif.btn_count_raw = 1'b0;
    bif.btn_clear_raw = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_both();
    test_clear_only();
    test_reset_mid_press();
    test_autorepeat();
    test_release_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
